// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: funct3 codes,
// FSM encoding, request record and the funct3 legality rule.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // 011/11x have no RV32I load/store meaning; stores have no unsigned forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory request/response bundle.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_is_load;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_load, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_load, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering: store byte enables / replicated write word, load
// lane extraction with sign/zero extension, and alignment check.
module dmem_responder_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rword,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wword,
  output logic [31:0]     rdata_ext,
  output logic            misalign
);

  logic [BE_W-1:0][7:0] rbytes;
  logic [7:0]           rb;
  logic [15:0]          rh;

  assign rbytes = rword;
  assign rb     = rbytes[addr_lo];
  assign rh     = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Write data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be       = '0;
    wword    = wdata;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = BE_W'(1) << addr_lo;
        wword = {BE_W{wdata[7:0]}};
      end
      2'b01: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        misalign = addr_lo[0];
      end
      2'b10: begin
        be       = '1;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:    rdata_ext = {{24{rb[7]}}, rb};
      F3_H:    rdata_ext = {{16{rh[15]}}, rh};
      F3_W:    rdata_ext = rword;
      F3_BU:   rdata_ext = {24'b0, rb};
      F3_HU:   rdata_ext = {16'b0, rh};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency, byte-enabled
// writes into an inferred RAM, RV32I load extension and fault reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 262144,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  state_e          state, state_nx;
  logic [CW-1:0]   cnt;
  dmem_req_t       req_q, cur;
  logic            accept, enter_resp, fault, misalign;
  logic            is_load_q, err_q;
  logic [BE_W-1:0] be;
  logic [31:0]     wword, rd_word, rdata_ext;
  logic [AW-1:0]   widx;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  // In IDLE the live bus request is used directly so WAIT_CYCLES=0 still works.
  always_comb begin
    cur = req_q;
    if (state == S_IDLE) begin
      cur.we     = bus.req_we;
      cur.funct3 = bus.req_funct3;
      cur.addr   = bus.req_addr;
      cur.wdata  = bus.req_wdata;
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign accept        = bus.req_valid && (state == S_IDLE);
  assign widx          = cur.addr[AW+1:2];

  dmem_responder_lane_align u_align (
    .funct3    (cur.funct3),
    .addr_lo   (cur.addr[1:0]),
    .wdata     (cur.wdata),
    .rword     (rd_word),
    .be        (be),
    .wword     (wword),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign fault = misalign || f3_illegal(cur.we, cur.funct3) || ({1'b0, cur.addr} >= MEM_BYTES);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == CW'(1)) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nx == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= cur;
        cnt   <= CW'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (enter_resp) begin
        is_load_q <= !cur.we;
        err_q     <= fault;
      end
    end
  end

  // Commit and read share the edge into RESP; a reset before it drops the store.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp) begin
      if (cur.we && !fault) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
      rd_word <= mem[widx];
    end
  end

  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_is_load = (state == S_RESP) && is_load_q;
  assign bus.rsp_err     = (state == S_RESP) && err_q;
  assign bus.rsp_rdata   = ((state == S_RESP) && is_load_q && !err_q) ? rdata_ext : '0;

endmodule
